// File: rtl/clock_pkg.sv
// clock_pkg: shared constants and state encoding for the hh:mm:ss timekeeper.
//   state_e  : set-mode FSM encoding (RUN, SET_HOUR, SET_MIN)
//   FIELD_W  : width of each binary time field
//   SEC_MAX  : last seconds value before the wrap
//   MIN_MAX  : last minutes value before the wrap
//   inc_wrap : modulo increment of a time field
package clock_pkg;

    localparam int FIELD_W = 6;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10
    } state_e;

    localparam logic [FIELD_W-1:0] SEC_MAX = 6'd59;
    localparam logic [FIELD_W-1:0] MIN_MAX = 6'd59;

    function automatic logic [FIELD_W-1:0] inc_wrap(input logic [FIELD_W-1:0] v,
                                                    input logic [FIELD_W-1:0] max);
        return (v == max) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: modulo-TICK_DIV counter producing a one-cycle tick.
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   en   in  count enable; the count is held while low
//   clr  in  return the count to zero
//   tick out high during the last count of each period (combinational)
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/time_counter.sv
// time_counter: free-running hh:mm:ss binary timekeeper with button set mode.
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   btn_mode   in   pulse: advance RUN -> SET_HOUR -> SET_MIN -> RUN
//   btn_inc    in   pulse: increment the field selected by the set mode
//   seconds    out  0..59
//   minutes    out  0..59
//   hours      out  0..HOURS_PER_DAY-1
//   tick_1hz   out  pulse on each seconds advance
//   day_wrap   out  pulse when the last second of the day rolls over
//   set_state  out  00 RUN, 01 SET_HOUR, 10 SET_MIN
module time_counter
    import clock_pkg::*;
#(
    parameter int TICK_DIV      = 100_000_000,
    parameter int HOURS_PER_DAY = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [5:0] hours,
    output logic       tick_1hz,
    output logic       day_wrap,
    output logic [1:0] set_state
);

    localparam logic [FIELD_W-1:0] HR_MAX = FIELD_W'(HOURS_PER_DAY - 1);

    state_e             state_q, state_d;
    logic [FIELD_W-1:0] sec_q, sec_d, min_q, min_d, hr_q, hr_d;
    logic               tick_1hz_q, day_wrap_q, day_wrap_d;
    logic               tick, run, exit_set, inc_hr, inc_min, sec_wrap, min_wrap;

    // Leaving SET_MIN restarts the second from zero so the new time starts cleanly.
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .clr  (exit_set),
        .tick (tick)
    );

    always_comb begin
        run        = (state_q == ST_RUN);
        exit_set   = (state_q == ST_SET_MIN) && btn_mode;
        // A mode press in the same cycle wins over an increment.
        inc_hr     = (state_q == ST_SET_HOUR) && btn_inc && !btn_mode;
        inc_min    = (state_q == ST_SET_MIN) && btn_inc && !btn_mode;
        sec_wrap   = tick && (sec_q == SEC_MAX);
        min_wrap   = sec_wrap && (min_q == MIN_MAX);
        sec_d      = exit_set ? '0 : tick ? inc_wrap(sec_q, SEC_MAX) : sec_q;
        min_d      = (sec_wrap || inc_min) ? inc_wrap(min_q, MIN_MAX) : min_q;
        hr_d       = (min_wrap || inc_hr) ? inc_wrap(hr_q, HR_MAX) : hr_q;
        day_wrap_d = min_wrap && (hr_q == HR_MAX);
        state_d    = !btn_mode ? state_q :
                     run ? ST_SET_HOUR :
                     (state_q == ST_SET_HOUR) ? ST_SET_MIN : ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            sec_q      <= '0;
            min_q      <= '0;
            hr_q       <= '0;
            tick_1hz_q <= 1'b0;
            day_wrap_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hr_q       <= hr_d;
            tick_1hz_q <= tick;
            day_wrap_q <= day_wrap_d;
        end
    end

    assign seconds   = sec_q;
    assign minutes   = min_q;
    assign hours     = hr_q;
    assign tick_1hz  = tick_1hz_q;
    assign day_wrap  = day_wrap_q;
    assign set_state = state_q;

endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: self-checking bench for time_counter with TICK_DIV=4.
module tb_time_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] seconds, minutes, hours;
    logic       tick_1hz, day_wrap;
    logic [1:0] set_state;

    time_counter #(.TICK_DIV(4), .HOURS_PER_DAY(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .seconds   (seconds),
        .minutes   (minutes),
        .hours     (hours),
        .tick_1hz  (tick_1hz),
        .day_wrap  (day_wrap),
        .set_state (set_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic       inc;
        logic [1:0] st;
        logic [5:0] hr;
        logic [5:0] mn;
        logic [5:0] sc;
        logic       tk;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        cyc();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic chk_time(input string tag, input int st, input int h, input int m, input int s);
        chk({tag, " state"}, int'(set_state), st);
        chk({tag, " hours"}, int'(hours), h);
        chk({tag, " minutes"}, int'(minutes), m);
        chk({tag, " seconds"}, int'(seconds), s);
    endtask

    initial begin
        int ticks, wraps, first_tick;
        vec_t v, e;

        // Simultaneous mode+inc in RUN, hour wrap, minute wrap, preload to 23:59.
        tbl.push_back('{1'b1, 1'b1, 2'd1, 6'd0, 6'd0, 6'd0, 1'b0});
        for (int i = 1; i <= 25; i++) tbl.push_back('{1'b0, 1'b1, 2'd1, 6'(i % 24), 6'd0, 6'd0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 2'd2, 6'd1, 6'd0, 6'd0, 1'b0});
        for (int i = 1; i <= 119; i++) tbl.push_back('{1'b0, 1'b1, 2'd2, 6'd1, 6'(i % 60), 6'd0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 2'd0, 6'd1, 6'd59, 6'd0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 2'd1, 6'd1, 6'd59, 6'd0, 1'b0});
        for (int i = 1; i <= 22; i++) tbl.push_back('{1'b0, 1'b1, 2'd1, 6'(1 + i), 6'd59, 6'd0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 2'd2, 6'd23, 6'd59, 6'd0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 2'd0, 6'd23, 6'd59, 6'd0, 1'b0});

        // Reset state.
        rst = 1'b1;
        cyc();
        cyc();
        chk_time("reset", 0, 0, 0, 0);
        chk("reset tick_1hz", int'(tick_1hz), 0);
        chk("reset day_wrap", int'(day_wrap), 0);

        // Free run for one minute.
        rst = 1'b0;
        ticks = 0;
        wraps = 0;
        for (int c = 1; c <= 240; c++) begin
            cyc();
            if (tick_1hz) ticks++;
            if (day_wrap) wraps++;
            if (c == 3) chk("first tick early seconds", int'(seconds), 0);
            if (c == 4) chk("first tick seconds", int'(seconds), 1);
            if (c == 4) chk("first tick pulse", int'(tick_1hz), 1);
        end
        chk_time("one minute", 0, 0, 1, 0);
        chk("one minute tick count", ticks, 60);
        chk("one minute day_wrap count", wraps, 0);

        // Restart from reset, then table-driven set-mode vectors via scoreboard.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        foreach (tbl[i]) begin
            v = tbl[i];
            sb.push_back(v);
            btn_mode = v.mode;
            btn_inc  = v.inc;
            cyc();
            btn_mode = 1'b0;
            btn_inc  = 1'b0;
            e = sb.pop_front();
            chk($sformatf("vec%0d state", i), int'(set_state), int'(e.st));
            chk($sformatf("vec%0d hours", i), int'(hours), int'(e.hr));
            chk($sformatf("vec%0d minutes", i), int'(minutes), int'(e.mn));
            chk($sformatf("vec%0d seconds", i), int'(seconds), int'(e.sc));
            chk($sformatf("vec%0d tick_1hz", i), int'(tick_1hz), int'(e.tk));
        end

        // From 23:59:00 with a freshly cleared prescaler, run to midnight.
        ticks = 0;
        wraps = 0;
        first_tick = 0;
        for (int c = 1; c <= 240; c++) begin
            cyc();
            if (tick_1hz) begin
                ticks++;
                if (first_tick == 0) first_tick = c;
            end
            if (day_wrap) begin
                wraps++;
                chk("day_wrap with tick_1hz", int'(tick_1hz), 1);
                chk("day_wrap at cycle", c, 240);
            end
            if (c == 236) chk_time("last second", 0, 23, 59, 59);
        end
        chk("first tick after set exit", first_tick, 4);
        chk("midnight tick count", ticks, 60);
        chk("midnight day_wrap count", wraps, 1);
        chk_time("midnight", 0, 0, 0, 0);

        // Reset while in SET_MIN with hours=5.
        press(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        chk_time("set min pre-reset", 2, 5, 0, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_time("reset in set", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
